// File: rtl/ila_pkg.sv
// Shared definitions for the ILA trigger-qualification block.
package ila_pkg;

    localparam int DATA_WIDTH_DEF    = 64;
    localparam int QUAL_WIDTH_DEF    = 4;
    localparam int HOLDOFF_WIDTH_DEF = 16;
    localparam int CNT_WIDTH_DEF     = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_FIRE    = 3'd2,
        ST_HOLDOFF = 3'd3
    } state_e;

    localparam logic [1:0] MODE_EQ   = 2'd0;
    localparam logic [1:0] MODE_RISE = 2'd1;
    localparam logic [1:0] MODE_FALL = 2'd2;
    localparam logic [1:0] MODE_NE   = 2'd3;

endpackage

// File: rtl/ila_match_unit.sv
// Stage 1: registers the probe word and produces a per-word hit from the
// masked compare plus optional edge detection on the match flag.
module ila_match_unit
    import ila_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] cfg_pattern,
    input  logic [DATA_WIDTH-1:0] cfg_mask,
    input  logic [1:0]            cfg_mode,
    output logic [DATA_WIDTH-1:0] s1_data,
    output logic                  s1_valid,
    output logic                  s1_hit
);

    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  hit_q, hit_d;
    logic                  prev_q, prev_d;
    logic                  match;

    // Masked compare, edge detect and previous-match tracking.
    always_comb begin
        match  = ((data_in ^ cfg_pattern) & cfg_mask) == '0;
        // prev only follows valid words so edges are seen across invalid gaps
        prev_d = data_valid ? match : prev_q;
        hit_d  = 1'b0;
        case (cfg_mode)
            MODE_EQ:   hit_d = match;
            MODE_RISE: hit_d = match & ~prev_q;
            MODE_FALL: hit_d = ~match & prev_q;
            MODE_NE:   hit_d = ~match;
            default:   hit_d = 1'b0;
        endcase
    end

    // Stage-1 registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            hit_q   <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            data_q  <= data_in;
            valid_q <= data_valid;
            hit_q   <= hit_d;
            prev_q  <= prev_d;
        end
    end

    assign s1_data  = data_q;
    assign s1_valid = valid_q;
    assign s1_hit   = hit_q;

endmodule

// File: rtl/ila_trigger.sv
// Trigger qualification: stage-1 match unit, qualifier/holdoff FSM and a
// stage-2 data register so trig_out lines up with the triggering word.
module ila_trigger
    import ila_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int QUAL_WIDTH    = QUAL_WIDTH_DEF,
    parameter int HOLDOFF_WIDTH = HOLDOFF_WIDTH_DEF,
    parameter int CNT_WIDTH     = CNT_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     data_valid,
    input  logic [DATA_WIDTH-1:0]    cfg_pattern,
    input  logic [DATA_WIDTH-1:0]    cfg_mask,
    input  logic [1:0]               cfg_mode,
    input  logic [QUAL_WIDTH-1:0]    cfg_qual,
    input  logic [HOLDOFF_WIDTH-1:0] cfg_holdoff,
    input  logic                     arm,
    input  logic                     disarm,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     data_out_valid,
    output logic                     trig_out,
    output logic [2:0]               state_out,
    output logic [CNT_WIDTH-1:0]     trig_count
);

    logic [DATA_WIDTH-1:0]    s1_data;
    logic                     s1_valid;
    logic                     s1_hit;

    logic [DATA_WIDTH-1:0]    data_q;
    logic                     valid_q;
    state_e                   state_q, state_d;
    logic [QUAL_WIDTH-1:0]    qual_q, qual_d;
    logic [HOLDOFF_WIDTH-1:0] hold_q, hold_d;
    logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;

    ila_match_unit #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_match (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .cfg_pattern (cfg_pattern),
        .cfg_mask    (cfg_mask),
        .cfg_mode    (cfg_mode),
        .s1_data     (s1_data),
        .s1_valid    (s1_valid),
        .s1_hit      (s1_hit)
    );

    // Next-state logic for the qualifier FSM and its counters.
    always_comb begin
        state_d = state_q;
        qual_d  = qual_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        if (disarm) begin
            state_d = ST_IDLE;
            qual_d  = '0;
            hold_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    qual_d = '0;
                    if (arm) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (s1_valid) begin
                        if (s1_hit) begin
                            // >= so a cfg_qual lowered mid-count still fires
                            if (qual_q >= cfg_qual) begin
                                state_d = ST_FIRE;
                                qual_d  = '0;
                                // counted on entry so it shows with trig_out
                                if (cnt_q != {CNT_WIDTH{1'b1}}) begin
                                    cnt_d = cnt_q + CNT_WIDTH'(1);
                                end
                            end else begin
                                qual_d = qual_q + QUAL_WIDTH'(1);
                            end
                        end else begin
                            qual_d = '0;
                        end
                    end
                end
                ST_FIRE: begin
                    state_d = ST_HOLDOFF;
                    hold_d  = cfg_holdoff;
                end
                ST_HOLDOFF: begin
                    if (hold_q == '0) begin
                        state_d = ST_ARMED;
                        qual_d  = '0;
                    end else begin
                        hold_d = hold_q - HOLDOFF_WIDTH'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM state, counters and the stage-2 data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            qual_q  <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            qual_q  <= qual_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            data_q  <= s1_data;
            valid_q <= s1_valid;
        end
    end

    assign data_out       = data_q;
    assign data_out_valid = valid_q;
    assign trig_out       = (state_q == ST_FIRE);
    assign state_out      = state_q;
    assign trig_count     = cnt_q;

endmodule

// File: tb/tb_ila_trigger.sv
// Scoreboard bench for ila_trigger: every driven word pushes its expected
// stage-2 output (data, valid, trigger, trigger count) due two cycles later.
module tb_ila_trigger;

    localparam int DW = 64;
    localparam int QW = 4;
    localparam int HW = 16;
    localparam int CW = 8;

    localparam logic [31:0] M = 32'hDEAD_BEEF;
    localparam logic [31:0] N = 32'h1234_5678;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          data_valid = 1'b0;
    logic [DW-1:0] cfg_pattern = '0;
    logic [DW-1:0] cfg_mask = '0;
    logic [1:0]    cfg_mode = 2'd0;
    logic [QW-1:0] cfg_qual = '0;
    logic [HW-1:0] cfg_holdoff = '0;
    logic          arm = 1'b0;
    logic          disarm = 1'b0;
    logic [DW-1:0] data_out;
    logic          data_out_valid;
    logic          trig_out;
    logic [2:0]    state_out;
    logic [CW-1:0] trig_count;

    ila_trigger #(
        .DATA_WIDTH    (DW),
        .QUAL_WIDTH    (QW),
        .HOLDOFF_WIDTH (HW),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in        (data_in),
        .data_valid     (data_valid),
        .cfg_pattern    (cfg_pattern),
        .cfg_mask       (cfg_mask),
        .cfg_mode       (cfg_mode),
        .cfg_qual       (cfg_qual),
        .cfg_holdoff    (cfg_holdoff),
        .arm            (arm),
        .disarm         (disarm),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .trig_out       (trig_out),
        .state_out      (state_out),
        .trig_count     (trig_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
        logic          valid;
        logic          trig;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          sb[$];
    int            cyc = 0;
    int            n_total = 0;
    int            n_bad = 0;
    logic [CW-1:0] exp_cnt = '0;

    // Output monitor: pops entries as they fall due, 1 time unit after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc = cyc + 1;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            n_total = n_total + 1;
            if (e.due != cyc) begin
                n_bad = n_bad + 1;
                $display("FAIL sb_late: due=%0d now=%0d", e.due, cyc);
            end
            n_total = n_total + 1;
            if (data_out !== e.data) begin
                n_bad = n_bad + 1;
                $display("FAIL data_out: got=%h exp=%h cyc=%0d", data_out, e.data, cyc);
            end
            n_total = n_total + 1;
            if (data_out_valid !== e.valid) begin
                n_bad = n_bad + 1;
                $display("FAIL data_out_valid: got=%b exp=%b cyc=%0d", data_out_valid, e.valid,
                         cyc);
            end
            n_total = n_total + 1;
            if (trig_out !== e.trig) begin
                n_bad = n_bad + 1;
                $display("FAIL trig_out: got=%b exp=%b cyc=%0d", trig_out, e.trig, cyc);
            end
            n_total = n_total + 1;
            if (trig_count !== e.cnt) begin
                n_bad = n_bad + 1;
                $display("FAIL trig_count: got=%0d exp=%0d cyc=%0d", trig_count, e.cnt, cyc);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Drive one word for one cycle and record what stage 2 must show for it.
    task automatic tick(input logic [31:0] lo, input logic v, input logic t,
                        input logic a = 1'b0, input logic d = 1'b0);
        logic [DW-1:0] w;
        @(negedge clk);
        w = {$urandom(), lo};
        data_in    = w;
        data_valid = v;
        arm        = a;
        disarm     = d;
        if (t && exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
        sb.push_back('{due: cyc + 2, data: w, valid: v, trig: t, cnt: exp_cnt});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(N, 1'b0, 1'b0);
    endtask

    task automatic check_state(input logic [2:0] exp, input string name);
        @(posedge clk);
        #2;
        n_total = n_total + 1;
        if (state_out !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: state_out got=%0d exp=%0d", name, state_out, exp);
        end
    endtask

    task automatic check_zero(input string name);
        n_total = n_total + 1;
        if (data_out !== '0 || data_out_valid !== 1'b0 || trig_out !== 1'b0 ||
            state_out !== 3'd0 || trig_count !== '0) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: data=%h v=%b trig=%b state=%0d cnt=%0d exp all zero", name,
                     data_out, data_out_valid, trig_out, state_out, trig_count);
        end
    endtask

    task automatic setup(input logic [1:0] mode, input logic [QW-1:0] q,
                         input logic [HW-1:0] h, input logic [DW-1:0] mask);
        tick(N, 1'b0, 1'b0, 1'b0, 1'b1);
        cfg_mode    = mode;
        cfg_qual    = q;
        cfg_holdoff = h;
        cfg_pattern = {32'h0, M};
        cfg_mask    = mask;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_level();
        setup(2'd0, 4'd2, 16'd3, {32'h0, 32'hFFFF_FFFF});
        tick(N, 1'b1, 1'b0, 1'b1);
        tick(M, 1'b1, 1'b0);
        tick(M, 1'b1, 1'b0);
        tick(M, 1'b1, 1'b1);
        idle(8);
        // Broken run: the non-match resets the qualifier
        tick(M, 1'b1, 1'b0);
        tick(N, 1'b1, 1'b0);
        tick(M, 1'b1, 1'b0);
        idle(4);
        check_state(3'd1, "level_still_armed");
    endtask

    task automatic test_rise_holdoff();
        setup(2'd1, 4'd0, 16'd5, {32'h0, 32'hFFFF_FFFF});
        tick(N, 1'b1, 1'b0);
        tick(N, 1'b1, 1'b0, 1'b1);
        tick(M, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) tick(M, 1'b1, 1'b0);
        tick(N, 1'b1, 1'b0);
        tick(M, 1'b1, 1'b1);
        // Rising edges inside the holdoff window are ignored
        for (int i = 0; i < 3; i++) begin
            tick(N, 1'b1, 1'b0);
            tick(M, 1'b1, 1'b0);
        end
        tick(N, 1'b1, 1'b0);
        idle(8);
    endtask

    task automatic test_invalid_gap();
        setup(2'd0, 4'd1, 16'd2, {32'h0, 32'hFFFF_FFFF});
        tick(N, 1'b1, 1'b0, 1'b1);
        tick(M, 1'b1, 1'b0);
        tick(N, 1'b0, 1'b0);
        tick(M, 1'b1, 1'b1);
        idle(6);
        // Edge across a gap: the invalid match word must not update prev
        setup(2'd1, 4'd0, 16'd2, {32'h0, 32'hFFFF_FFFF});
        tick(N, 1'b1, 1'b0, 1'b1);
        tick(M, 1'b0, 1'b0);
        tick(M, 1'b1, 1'b1);
        idle(6);
    endtask

    task automatic test_disarm();
        setup(2'd0, 4'd0, 16'd2, {32'h0, 32'hFFFF_FFFF});
        tick(N, 1'b1, 1'b0, 1'b1);
        check_state(3'd1, "disarm_armed");
        tick(N, 1'b1, 1'b0, 1'b1, 1'b1);
        check_state(3'd0, "disarm_vs_arm");
        tick(N, 1'b1, 1'b0, 1'b1);
        tick(M, 1'b1, 1'b0);
        tick(N, 1'b1, 1'b0, 1'b0, 1'b1);
        check_state(3'd0, "disarm_before_fire");
        idle(4);
        check_state(3'd0, "disarm_stays_idle");
    endtask

    task automatic test_saturate_masks();
        setup(2'd0, 4'd0, 16'd0, '0);
        tick(N, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 780; k++) tick(k, 1'b1, (k % 3) == 0);
        setup(2'd3, 4'd0, 16'd0, '0);
        tick(N, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 20; k++) tick($urandom(), 1'b1, 1'b0);
        idle(3);
    endtask

    task automatic test_reset_mid();
        setup(2'd0, 4'd0, 16'd20, {32'h0, 32'hFFFF_FFFF});
        tick(N, 1'b1, 1'b0, 1'b1);
        tick(M, 1'b1, 1'b1);
        idle(4);
        check_state(3'd3, "reset_mid_holdoff");
        #2;
        rst_n = 1'b0;
        sb.delete();
        exp_cnt = '0;
        #1;
        check_zero("reset_mid_async");
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        check_state(3'd0, "reset_mid_idle");
    endtask

    initial begin
        test_reset();
        test_level();
        test_rise_holdoff();
        test_invalid_gap();
        test_disarm();
        test_saturate_masks();
        test_reset_mid();
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #3;
        n_total = n_total + 1;
        if (sb.size() != 0) begin
            n_bad = n_bad + 1;
            $display("FAIL drain: pending=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ila_trigger.md
Name: ila_trigger

Overview:
- Trigger-qualification stage directly upstream of the ILA capture block.
- Registers the 64-bit probe word and compares it against a software pattern/mask, with a selectable match mode.
- Qualifies matches by a consecutive-count requirement, then enforces a holdoff before re-arming.
- Emits a one-cycle trigger pulse aligned with a delayed copy of the probe data, so the capture stage records the triggering word at a known position.

Parameters:
- DATA_WIDTH, 64, probe word width.
- QUAL_WIDTH, 4, width of the consecutive-match qualifier count.
- HOLDOFF_WIDTH, 16, width of the post-trigger holdoff counter.
- CNT_WIDTH, 16, width of the trigger event counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  DATA_WIDTH  probe word.
- data_valid  in  1  probe word qualifier.
- cfg_pattern  in  DATA_WIDTH  compare pattern (software register).
- cfg_mask  in  DATA_WIDTH  1 = bit participates in compare.
- cfg_mode  in  2  0 level-equal, 1 rising edge of match, 2 falling edge of match, 3 level-not-equal.
- cfg_qual  in  QUAL_WIDTH  consecutive qualifying valid words required, minus 1.
- cfg_holdoff  in  HOLDOFF_WIDTH  cycles spent in HOLDOFF after a trigger.
- arm  in  1  single-cycle pulse: arm the trigger.
- disarm  in  1  single-cycle pulse: abort to IDLE.
- data_out  out  DATA_WIDTH  data_in delayed 2 cycles.
- data_out_valid  out  1  data_valid delayed 2 cycles.
- trig_out  out  1  one-cycle pulse aligned with the triggering data_out word.
- state_out  out  3  current FSM state encoding.
- trig_count  out  CNT_WIDTH  triggers fired since reset; saturates.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, FSM in IDLE, and all internal counters and registers 0.
- Pipeline stage 1 registers data_in and data_valid, and computes match = ((d ^ cfg_pattern) & cfg_mask) == 0.
  - For mode 3 the hit is !match.
  - The previous-match flag updates only on valid words.
  - Rising-edge hit = match & !prev; falling-edge hit = !match & prev.
  - prev resets to 0.
  - All-zero mask: match = 1 always.
- Stage 2 registers data and valid to data_out/data_out_valid. trig_out is asserted in the same cycle as the stage-2 word that completed qualification.
- FSM states:
  - IDLE=0: arm moves to ARMED; qual_cnt is cleared.
  - ARMED=1, on a stage-1 valid word:
    - Hit with qual_cnt == cfg_qual: go to FIRE.
    - Hit with qual_cnt < cfg_qual: increment qual_cnt.
    - No hit: clear qual_cnt.
    - Invalid words neither count nor clear.
  - FIRE=2: lasts exactly one cycle. trig_out=1 and trig_count increments (holds at all-ones). Next state is HOLDOFF, with the holdoff counter loaded with cfg_holdoff.
  - HOLDOFF=3:
    - Counter decrements each cycle.
    - At 0, go to ARMED with qual_cnt cleared (auto re-arm).
    - cfg_holdoff = 0 gives one cycle in HOLDOFF.
- disarm has priority over every transition: the next state is IDLE from any state, counters clear, and no trig_out is issued that cycle even if FIRE was pending. If disarm and arm arrive together, disarm wins.
- arm outside IDLE is ignored.
- Config inputs are sampled every cycle; changing them mid-qualification takes effect on the next valid word. qual_cnt is not cleared on a config change.
- Edge modes evaluate prev across invalid gaps; only valid words update prev.
- Latency:
  - data_in to data_out: 2 cycles.
  - Triggering word at data_in in cycle N gives trig_out in cycle N+2 with that word on data_out.
- The downstream capture stage consumes trig_out as its trigger; the block does not backpressure.

Decomposition:
- Shared package ila_pkg holds:
  - FSM state encodings (ST_IDLE, ST_ARMED, ST_FIRE, ST_HOLDOFF).
  - cfg_mode constants (MODE_EQ, MODE_RISE, MODE_FALL, MODE_NE).
  - Default width constants.
- One sub-module, ila_match_unit: the registered masked comparator plus edge detect, producing hit and the stage-1 data/valid.
- FSM, counters and stage 2 live in ila_trigger.

Test Plan:
- Reset mid-operation: assert rst_n low while in HOLDOFF → outputs 0 immediately, state_out=0, trig_count=0.
- Level qualification: mode 0, pattern 0x00000000_DEADBEEF, mask 0x00000000_FFFFFFFF, cfg_qual 2, arm. Drive 3 consecutive valid matching words at cycles 10–12 → trig_out=1 at cycle 14, with data_out equal to the cycle-12 word. A non-match at cycle 11 instead → no trigger.
- Rising edge and holdoff: mode 1, cfg_qual 0, cfg_holdoff 5, drive the match high continuously → exactly one trig_out. Then toggle 0/1 → next trig_out no sooner than 7 cycles after the first. trig_count=2.
- Invalid gaps: mode 0, cfg_qual 1, drive the sequence match, invalid, match → trigger fires (the invalid word neither counts nor clears).
- Disarm priority: hold arm and disarm together in ARMED → IDLE. Disarm in the cycle FIRE would be entered → no trig_out, trig_count unchanged.
- Saturation and masks:
  - Force trig_count to 0xFFFF via repeated triggers with cfg_holdoff 0 → holds at 0xFFFF.
  - mask=0 → trigger on the first valid word after arm (mode 0). No trigger ever in mode 3.
